// File: rtl/alarm_scheduler.sv
// Alarm controller: stores a user-set alarm time, compares it against the
// running clock time and sequences IDLE / ARMED / RINGING / SNOOZE.
//
// Handshake note: every control input is a single-cycle pulse that is acted
// on in the cycle it is high. There is no back-pressure (no ready), and all
// outputs are registered, so responses appear on the following cycle.
module alarm_scheduler #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SNOOZE_MINS = 5,
    parameter int RING_SECS   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic       arm_toggle,
    input  logic       sel,
    input  logic       plus,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_mins,
    output logic [1:0] edit_field,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state_dbg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [4:0]      target_h;
    logic [5:0]      target_m;
    logic [4:0]      target_h_next;
    logic [5:0]      target_m_next;

    logic [TW-1:0]   tick_cnt;
    logic [TW-1:0]   tick_cnt_next;
    logic [7:0]      sec_cnt;
    logic [7:0]      sec_cnt_next;

    logic [4:0]      alarm_h_ed;
    logic [5:0]      alarm_m_ed;
    logic [1:0]      field_ed;
    logic [1:0]      field_next;

    logic [6:0]      snz_sum;
    logic [4:0]      snz_h;
    logic [5:0]      snz_m;

    logic            cmp_now;
    logic            cmp_q;
    logic            cmp_d;
    logic            match;
    logic            ring_done;
    logic            ring_entry;

    // Compare the live time against the target; only the rising edge of
    // the registered compare counts, so a held hh:mm:00 fires once.
    assign cmp_now   = (hours == target_h) && (mins == target_m) && (secs == 6'd0);
    assign match     = cmp_q & ~cmp_d;
    assign ring_done = (sec_cnt == 8'(RING_SECS));

    // Alarm editing: sel cycles the field, plus bumps it with per-field wrap.
    always_comb begin
        alarm_h_ed = alarm_hours;
        alarm_m_ed = alarm_mins;
        field_ed   = edit_field;
        if ((state == S_IDLE) || (state == S_ARMED)) begin
            if (plus) begin
                case (edit_field)
                    2'b01:   alarm_m_ed = (alarm_mins == 6'd59) ? 6'd0 : alarm_mins + 6'd1;
                    2'b10:   alarm_h_ed = (alarm_hours == 5'd23) ? 5'd0 : alarm_hours + 5'd1;
                    default: ;
                endcase
            end
            if (sel) begin
                field_ed = (edit_field == 2'b10) ? 2'b00 : edit_field + 2'd1;
            end
        end
    end

    // Snoozed target: add minutes, carry into hours, hours wrap past 23.
    always_comb begin
        snz_sum = {1'b0, target_m} + 7'(SNOOZE_MINS);
        snz_h   = target_h;
        snz_m   = snz_sum[5:0];
        if (snz_sum >= 7'd60) begin
            snz_m = 6'(snz_sum - 7'd60);
            snz_h = (target_h == 5'd23) ? 5'd0 : target_h + 5'd1;
        end
    end

    // Next-state logic; arm_toggle beats stop beats snooze beats timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (arm_toggle) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (arm_toggle)  state_next = S_IDLE;
                else if (match)  state_next = S_RINGING;
            end
            S_RINGING: begin
                if (arm_toggle)     state_next = S_IDLE;
                else if (stop)      state_next = S_ARMED;
                else if (snooze)    state_next = S_SNOOZE;
                else if (ring_done) state_next = S_ARMED;
            end
            S_SNOOZE: begin
                if (arm_toggle)  state_next = S_IDLE;
                else if (match)  state_next = S_RINGING;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ring_entry = (state_next == S_RINGING) && (state != S_RINGING);

    // Datapath next values: target, edit field and the ring timer.
    always_comb begin
        target_h_next = target_h;
        target_m_next = target_m;
        field_next    = field_ed;
        tick_cnt_next = tick_cnt;
        sec_cnt_next  = sec_cnt;

        if ((state == S_RINGING) && (state_next == S_SNOOZE)) begin
            target_h_next = snz_h;
            target_m_next = snz_m;
        end else if ((state == S_ARMED) || (state_next == S_ARMED)) begin
            // While armed the target tracks the (possibly just edited)
            // alarm time; arming and leaving RINGING reload it.
            target_h_next = alarm_h_ed;
            target_m_next = alarm_m_ed;
        end

        if (ring_entry) begin
            field_next    = 2'b00;
            tick_cnt_next = '0;
            sec_cnt_next  = 8'd0;
        end else if (state == S_RINGING) begin
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt_next = '0;
                sec_cnt_next  = sec_cnt + 8'd1;
            end else begin
                tick_cnt_next = tick_cnt + TW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hours <= 5'd0;
            alarm_mins  <= 6'd0;
            edit_field  <= 2'b00;
            target_h    <= 5'd0;
            target_m    <= 6'd0;
            tick_cnt    <= '0;
            sec_cnt     <= 8'd0;
            cmp_q       <= 1'b0;
            cmp_d       <= 1'b0;
        end else begin
            alarm_hours <= alarm_h_ed;
            alarm_mins  <= alarm_m_ed;
            edit_field  <= field_next;
            target_h    <= target_h_next;
            target_m    <= target_m_next;
            tick_cnt    <= tick_cnt_next;
            sec_cnt     <= sec_cnt_next;
            cmp_q       <= cmp_now;
            cmp_d       <= cmp_q;
        end
    end

    assign armed     = (state != S_IDLE);
    assign ringing   = (state == S_RINGING);
    assign snoozing  = (state == S_SNOOZE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios plus random pulses, checked
// every cycle against a minutes-of-day reference model.
module tb_alarm_scheduler;

    localparam int TD = 10;
    localparam int RS = 3;
    localparam int SM = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       arm_toggle, sel, plus, snooze, stop;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_mins;
    logic [1:0] edit_field;
    logic       armed, ringing, snoozing;
    logic [1:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 idle, 1 armed, 2 ringing, 3 snooze
    int m_mode, m_ah, m_am, m_field, m_tgt, m_c1, m_c2, m_ring;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    alarm_scheduler #(.TICK_DIV(TD), .SNOOZE_MINS(SM), .RING_SECS(RS)) dut (
        .clk(clk), .reset(reset), .hours(hours), .mins(mins), .secs(secs),
        .arm_toggle(arm_toggle), .sel(sel), .plus(plus), .snooze(snooze),
        .stop(stop), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
        .edit_field(edit_field), .armed(armed), .ringing(ringing),
        .snoozing(snoozing), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic at, input logic sl,
                              input logic pl, input logic sz, input logic sp);
        int eq_now, match, ah, am, fld, nm;
        if (rst) begin
            m_mode = 0; m_ah = 0; m_am = 0; m_field = 0;
            m_tgt = 0; m_c1 = 0; m_c2 = 0; m_ring = 0;
        end else begin
            eq_now = (int'(hours) == m_tgt / 60 && int'(mins) == m_tgt % 60 && secs == 0) ? 1 : 0;
            match  = (m_c1 == 1 && m_c2 == 0) ? 1 : 0;
            m_c2 = m_c1;
            m_c1 = eq_now;
            ah = m_ah; am = m_am; fld = m_field;
            if (m_mode <= 1) begin
                if (pl) begin
                    if (fld == 1) am = (am + 1) % 60;
                    else if (fld == 2) ah = (ah + 1) % 24;
                end
                if (sl) fld = (fld + 1) % 3;
            end
            nm = m_mode;
            case (m_mode)
                0: if (at) nm = 1;
                1: if (at) nm = 0; else if (match == 1) nm = 2;
                2: begin
                    if (at) nm = 0;
                    else if (sp) nm = 1;
                    else if (sz) begin nm = 3; m_tgt = (m_tgt + SM) % 1440; end
                    else if (m_ring == RS * TD) nm = 1;
                    else m_ring++;
                end
                default: if (at) nm = 0; else if (match == 1) nm = 2;
            endcase
            if (m_mode == 1 || nm == 1) m_tgt = ah * 60 + am;
            if (nm == 2 && m_mode != 2) begin m_ring = 0; fld = 0; end
            m_mode = nm; m_ah = ah; m_am = am; m_field = fld;
        end
        exp_q.push_back({(m_mode != 0), (m_mode == 2), (m_mode == 3),
                         2'(m_field), 5'(m_ah), 6'(m_am)});
    endtask

    task automatic tick(input logic at, input logic sl, input logic pl,
                        input logic sz, input logic sp);
        logic [15:0] e;
        arm_toggle = at; sel = sl; plus = pl; snooze = sz; stop = sp;
        @(posedge clk);
        model_step(reset, at, sl, pl, sz, sp);
        #1;
        e = exp_q.pop_front();
        check("armed",       armed,       e[15]);
        check("ringing",     ringing,     e[14]);
        check("snoozing",    snoozing,    e[13]);
        check("edit_field",  edit_field,  e[12:11]);
        check("alarm_hours", alarm_hours, e[10:6]);
        check("alarm_mins",  alarm_mins,  e[5:0]);
        arm_toggle = 0; sel = 0; plus = 0; snooze = 0; stop = 0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic plus_n(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 1, 0, 0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours = 5'(h); mins = 6'(m); secs = 6'(s);
    endtask

    // Step the time off hh:mm:00 and back so a fresh match edge occurs.
    task automatic refire(input int h, input int m);
        set_time(h, m, 1); tick(0, 0, 0, 0, 0);
        set_time(h, m, 0); tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        int ring_cnt, rises, prev, r;
        reset = 1; set_time(0, 0, 0);
        arm_toggle = 0; sel = 0; plus = 0; snooze = 0; stop = 0;
        idle_n(2);
        check("rst_status", {armed, ringing, snoozing}, 0);
        check("rst_alarm", {alarm_hours, alarm_mins, edit_field}, 0);
        reset = 0;

        // editing
        tick(0, 1, 0, 0, 0); plus_n(3); tick(0, 1, 0, 0, 0); plus_n(7);
        check("edit_hours", alarm_hours, 7);
        check("edit_mins", alarm_mins, 3);
        plus_n(17);
        check("hours_wrap", alarm_hours, 0);
        plus_n(7);
        tick(0, 1, 0, 0, 0);
        check("field_back_none", edit_field, 0);

        // fire and auto-stop
        tick(1, 0, 0, 0, 0);
        check("armed_on", armed, 1);
        set_time(7, 2, 59); tick(0, 0, 0, 0, 0);
        set_time(7, 3, 0);  tick(0, 0, 0, 0, 0);
        check("fire_lat1", ringing, 0);
        tick(0, 0, 0, 0, 0);
        check("fire_lat2", ringing, 1);
        ring_cnt = 1; rises = 1; prev = 1;
        for (int i = 0; i < 98; i++) begin
            tick(0, 0, 0, 0, 0);
            if (ringing) ring_cnt++;
            if (ringing && prev == 0) rises++;
            prev = int'(ringing);
        end
        check("ring_len", ring_cnt, RS * TD + 1);
        check("ring_once", rises, 1);
        check("after_timeout", {armed, ringing}, 2'b10);

        // priority: stop beats snooze
        refire(7, 3);
        check("ring_again", ringing, 1);
        tick(0, 0, 0, 1, 1);
        check("stop_snooze", {armed, ringing, snoozing}, 3'b100);

        // edit lockout while ringing, then arm_toggle beats stop
        refire(7, 3);
        tick(0, 1, 0, 0, 0); tick(0, 0, 1, 0, 0);
        check("lock_field", edit_field, 0);
        check("lock_alarm", {alarm_hours, alarm_mins}, {5'd7, 6'd3});
        check("lock_ringing", ringing, 1);
        tick(1, 0, 0, 0, 1);
        check("arm_stop", armed, 0);

        // snooze across midnight with alarm 23:58
        tick(0, 1, 0, 0, 0); plus_n(55); tick(0, 1, 0, 0, 0); plus_n(16);
        tick(0, 1, 0, 0, 0);
        check("alarm_2358", {alarm_hours, alarm_mins}, {5'd23, 6'd58});
        tick(1, 0, 0, 0, 0);
        set_time(23, 57, 59); tick(0, 0, 0, 0, 0);
        set_time(23, 58, 0);  tick(0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0);
        check("ring_2358", ringing, 1);
        tick(0, 0, 0, 1, 0);
        check("snoozing", snoozing, 1);
        set_time(0, 2, 59); tick(0, 0, 0, 0, 0);
        set_time(0, 3, 0);  tick(0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0);
        check("snooze_wrap_ring", ringing, 1);

        // reset mid-ring
        reset = 1; tick(0, 0, 0, 0, 0);
        check("mid_rst", {armed, ringing, snoozing, edit_field, alarm_hours, alarm_mins}, 0);
        reset = 0;
        set_time(0, 0, 59); tick(0, 0, 0, 0, 0);
        set_time(0, 0, 0);  idle_n(3);
        check("no_ring_idle", {armed, ringing}, 0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 3 && r < 6) set_time(m_tgt / 60, m_tgt % 60, $urandom_range(0, 1));
            else if (r >= 6 && r < 8) secs = 6'($urandom_range(0, 59));
            else if (r >= 8) set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            reset = ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 59) == 0);
        end
        reset = 0;
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Alarm controller for the watch datapath. It holds a user-set alarm time and compares it against the running clock time (hours/mins/secs from the clock-time block). It sequences an IDLE / ARMED / RINGING / SNOOZE state machine and drives the ring output to the LED/buzzer path. Button inputs arrive already debounced and edge-detected as single-cycle pulses; the top level gates them by display mode.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second for the internal ring/timeout timer.
- SNOOZE_MINS, 5: minutes added to the current ring target on snooze (1..59).
- RING_SECS, 60: seconds of ringing before auto-stop (1..255).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- hours  in  5  current clock hours, 0..23
- mins  in  6  current clock minutes, 0..59
- secs  in  6  current clock seconds, 0..59
- arm_toggle  in  1  one-cycle pulse; arm/disarm
- sel  in  1  one-cycle pulse; cycle edit field
- plus  in  1  one-cycle pulse; increment selected field
- snooze  in  1  one-cycle pulse; snooze while ringing
- stop  in  1  one-cycle pulse; silence while ringing
- alarm_hours  out  5  stored alarm hours
- alarm_mins  out  6  stored alarm minutes
- edit_field  out  2  00 none, 01 minutes, 10 hours
- armed  out  1  high in ARMED, RINGING, SNOOZE
- ringing  out  1  high in RINGING only
- snoozing  out  1  high in SNOOZE only

## Operation
- Reset values:
  - State: IDLE.
  - alarm_hours and alarm_mins: 0.
  - edit_field: 00.
  - Target register: 00:00.
  - Tick counter and ring-seconds counter: 0.
  - All status outputs: 0.
- States and transitions:
  - IDLE: arm_toggle -> ARMED, with target loaded from the alarm time.
  - ARMED: a match event -> RINGING; arm_toggle -> IDLE.
  - RINGING:
    - stop -> ARMED, with target reloaded from the alarm time.
    - snooze -> SNOOZE, with target = target + SNOOZE_MINS.
    - RING_SECS elapsed -> ARMED, with target reloaded.
    - arm_toggle -> IDLE.
  - SNOOZE: a match event -> RINGING; arm_toggle -> IDLE.
- Match event: hours==target_h && mins==target_m && secs==0, evaluated only on the cycle the condition becomes true (rising edge of the registered compare). A time that stays at hh:mm:00 for many cycles fires once.
- Snooze add: target_m + SNOOZE_MINS; on reaching ≥60, subtract 60 and increment target_h. target_h wraps 23 -> 0.
- Editing:
  - sel cycles edit_field 00 -> 01 -> 10 -> 00.
  - plus increments the selected field; alarm_mins wraps 59 -> 0 and alarm_hours wraps 23 -> 0, with no carry between fields.
  - plus with edit_field 00 is ignored.
  - Editing is allowed in IDLE and ARMED. In ARMED, the target register follows the edited alarm time in the same cycle.
  - In RINGING and SNOOZE, sel and plus are ignored, and edit_field is forced to 00 on entry to RINGING.
- Simultaneous pulses, priority high to low: arm_toggle, stop, snooze. A match event coinciding with arm_toggle in ARMED goes to IDLE.
- Ring timer:
  - On entry to RINGING, the tick and seconds counters clear.
  - The tick counter counts 0..TICK_DIV-1; each wrap increments the ring-seconds counter.
  - When ring-seconds reaches RING_SECS, the next cycle is ARMED.

## Timing
- All outputs are registered. A state change appears on the cycle after the causing pulse or time edge.
- Match latency: the compare is registered, so ringing rises 2 cycles after secs first becomes 0 at the target minute.
- Auto-stop: ringing is high for exactly RING_SECS*TICK_DIV cycles (+1 for the exit registration).
- alarm_hours/alarm_mins update 1 cycle after plus.
- Reset mid-ring: ringing drops on the cycle after reset is sampled. Stored alarm time is also cleared.

## Test plan
- Edit: reset, then sel, plus×3, sel, plus×7 -> alarm 07:03. Then plus×17 on hours -> alarm_hours 0 (wrap 23->0).
- Fire: alarm 07:03, arm_toggle, drive time 07:02:59 -> 07:03:00 and hold 100 cycles -> ringing rises 2 cycles after the edge, exactly once. With TICK_DIV=10 and RING_SECS=3, ringing lasts 30 cycles (+1), then armed=1, ringing=0.
- Snooze wrap: alarm 23:58, SNOOZE_MINS=5, ring then snooze -> snoozing=1. Time 00:03:00 -> ringing again.
- Priority: in RINGING, pulse stop+snooze together -> ARMED. Pulse arm_toggle+stop together -> IDLE, armed=0.
- Edit lockout: in RINGING, pulse sel and plus -> alarm time and edit_field unchanged (edit_field 00).
- Reset mid-ring: assert reset while ringing -> the next cycle has all outputs 0 and alarm 00:00. After deassert, time 00:00:00 does not ring (IDLE).
